// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB types: FSM states, default widths, response record
package apb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] rdata;
        logic                  err;
    } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// rtl/apb_timeout_cnt.sv - ACCESS wait-state counter, used when APB_MASTER_TIMEOUT_EN is defined
module apb_timeout_cnt #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // expired flags the wait cycle in which the count reaches TIMEOUT_CYC
    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_W'(TIMEOUT_CYC))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - valid/ready command to APB3 master, one transfer in flight.
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    apb_state_t        state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              accept;
    logic              timeout_expired;

    assign accept = (state_q == IDLE) && req_valid && req_ready_q;

`ifdef APB_MASTER_TIMEOUT_EN
    apb_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .enable ((state_q == ACCESS) && !pready),
        .expired(timeout_expired)
    );
`else
    assign timeout_expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    pwrite_d  = req_write;
                    paddr_d   = req_addr;
                    pwdata_d  = req_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // pready wins over a timeout landing in the same cycle
                if (pready) begin
                    rsp_rdata_d = (pwrite_q || pslverr) ? '0 : prdata;
                    rsp_err_d   = pslverr;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (timeout_expired) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - scoreboard bench for apb_master (timeout checks follow APB_MASTER_TIMEOUT_EN)
module tb_apb_master;
    import apb_pkg::*;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    int                errors = 0;
    int                checks = 0;
    apb_rsp_t          sb_q[$];
    logic [ADDR_W-1:0] last_addr;

    always #5 clk = ~clk;

    apb_master #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the first ACCESS negedge.
    task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic first_pready);
        check_val("req_ready_idle", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        last_addr = addr;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = ~wdata;
        check_val("setup_psel_pen", 64'({psel, penable}), 64'(2'b10));
        check_val("setup_req_ready", 64'(req_ready), 64'(0));
        pready = first_pready;
        @(negedge clk);
        check_val("access_psel_pen", 64'({psel, penable}), 64'(2'b11));
        check_val("access_paddr", 64'(paddr), 64'(addr));
        check_val("access_pwdata", 64'(pwdata), 64'(wdata));
        check_val("access_pwrite", 64'(pwrite), 64'(wr));
    endtask

    // Called at the negedge where rsp_valid is expected.
    task automatic finish_rsp(input int hold);
        apb_rsp_t e;
        pready  = 1'b0;
        pslverr = 1'b0;
        check_val("rsp_valid", 64'(rsp_valid), 64'(1));
        check_val("rsp_psel_pen", 64'({psel, penable}), 64'(0));
        check_val("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_val("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            check_val("rsp_err", 64'(rsp_err), 64'(e.err));
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_val("hold_valid", 64'(rsp_valid), 64'(1));
                check_val("hold_rdata", 64'(rsp_rdata), 64'(e.rdata));
                check_val("hold_err", 64'(rsp_err), 64'(e.err));
                check_val("hold_req_ready", 64'(req_ready), 64'(0));
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_val("idle_rsp_valid", 64'(rsp_valid), 64'(0));
        check_val("idle_req_ready", 64'(req_ready), 64'(1));
        check_val("idle_paddr_kept", 64'(paddr), 64'(last_addr));
    endtask

    task automatic do_xfer(input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input int waits,
                           input logic [DATA_W-1:0] sdata, input logic serr, input int hold);
        apb_rsp_t e;
        e.rdata = (wr || serr) ? '0 : sdata;
        e.err   = serr;
        sb_q.push_back(e);
        prdata  = sdata;
        pslverr = serr;
        issue(wr, addr, wdata, waits == 0);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check_val("wait_state", 64'({psel, penable, rsp_valid}), 64'(3'b110));
            if (i == waits - 1) pready = 1'b1;
        end
        @(negedge clk);
        finish_rsp(hold);
    endtask

    initial begin
        int       cnt;
        apb_rsp_t e;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        last_addr = '0;
        @(negedge clk);
        check_val("rst_apb", 64'({psel, penable, pwrite, paddr, pwdata}), 64'(0));
        check_val("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
        check_val("rst_req_ready", 64'(req_ready), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        do_xfer(1'b1, 8'h03, 32'hDEADBEEF, 0, 32'hA5A5A5A5, 1'b0, 0);
        do_xfer(1'b0, 8'h04, 32'h0, 3, 32'h12345678, 1'b0, 0);
        do_xfer(1'b0, 8'h10, 32'h0, 0, 32'hCAFEF00D, 1'b0, 5);
        do_xfer(1'b1, 8'h20, 32'h01020304, 1, 32'h0, 1'b0, 0);
        do_xfer(1'b0, 8'h05, 32'h0, 0, 32'hFFFF0000, 1'b1, 0);
        do_xfer(1'b1, 8'h06, 32'h55AA55AA, 2, 32'h0, 1'b1, 0);
        for (int k = 0; k < 6; k++) begin
            do_xfer(1'($urandom_range(0, 1)), 8'($urandom), $urandom, int'($urandom_range(0, 4)),
                    $urandom, 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
        end

        // reset in a wait state: no response for the aborted read
        prdata = 32'h0BADF00D;
        issue(1'b0, 8'h07, 32'h0, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_val("rst_mid_apb", 64'({psel, penable}), 64'(0));
        check_val("rst_mid_rsp", 64'({rsp_valid, req_ready}), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("post_rst_idle", 64'({req_ready, psel, rsp_valid}), 64'(3'b100));
        last_addr = '0;

        // pready stuck low
        prdata = 32'h13579BDF;
        issue(1'b0, 8'h08, 32'h0, 1'b0);
        last_addr = 8'h08;
`ifdef APB_MASTER_TIMEOUT_EN
        e.rdata = '0;
        e.err   = 1'b1;
        sb_q.push_back(e);
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
            if (penable) cnt++;
        end
        check_val("timeout_access_cycles", 64'(cnt), 64'(TIMEOUT_CYC));
        finish_rsp(0);
`else
        cnt = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (psel && penable && !rsp_valid) cnt++;
        end
        check_val("no_timeout_access", 64'(cnt), 64'(101));
        e.rdata = prdata;
        e.err   = 1'b0;
        sb_q.push_back(e);
        pready = 1'b1;
        @(negedge clk);
        finish_rsp(0);
`endif

        check_val("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
